// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / halt controller.
package hazard_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes,
// halt/drain handshake and saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             halt_req,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  hz_state_t  state;
  logic [3:0] drain_ctr;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;

  always_comb begin
    load_use = id_valid && ex_memread && (ex_rd != REG_ZERO) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  end

  // A taken branch overrides everything except HALTED, where none can be in flight.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (mem_branch_taken && (state != HALTED)) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      flush_inc   = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end
        end
        DRAIN: begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
        HALTED: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Drain keeps counting through a taken branch; the fetched target gets flushed anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_ctr <= 4'd0;
      halt_ack  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_req) begin
            state     <= DRAIN;
            drain_ctr <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (drain_ctr == 4'd0) begin
            state    <= HALTED;
            halt_ack <= 1'b1;
          end else begin
            drain_ctr <= drain_ctr - 4'd1;
          end
        end
        HALTED: begin
          if (!halt_req) begin
            state    <= RUN;
            halt_ack <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          halt_ack <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle behavioural model compare
// plus directed literal expectations (DRAIN_CYCLES=4, CNT_W=4).
module tb_hazard_ctrl;

  localparam int DRAIN_N = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_HALT  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_uses_rs2, ex_memread, mem_branch_taken, halt_req, cnt_clr;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, halt_ack;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int passCount  = 0;
  int checkCount = 0;
  bit checkOn    = 1'b0;

  int mMode      = M_RUN;
  int mDrainLeft = 0;
  int mAck       = 0;
  int mStall     = 0;
  int mFlush     = 0;

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN_N), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_valid         (id_valid),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_uses_rs2      (id_uses_rs2),
    .ex_memread       (ex_memread),
    .ex_rd            (ex_rd),
    .mem_branch_taken (mem_branch_taken),
    .halt_req         (halt_req),
    .cnt_clr          (cnt_clr),
    .pc_en            (pc_en),
    .ifid_en          (ifid_en),
    .ifid_flush       (ifid_flush),
    .idex_flush       (idex_flush),
    .exmem_flush      (exmem_flush),
    .halt_ack         (halt_ack),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input bit v, input bit mr, input int rd, input int rs1,
                               input int rs2, input bit u2, input bit br, input bit hr,
                               input bit clr);
    id_valid         = v;
    ex_memread       = mr;
    ex_rd            = 5'(rd);
    id_rs1           = 5'(rs1);
    id_rs2           = 5'(rs2);
    id_uses_rs2      = u2;
    mem_branch_taken = br;
    halt_req         = hr;
    cnt_clr          = clr;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Inputs change and literal checks happen just after the falling edge.
  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  function automatic bit modelLoadUse();
    return id_valid && ex_memread && (ex_rd != 0) &&
           ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  endfunction

  // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush}
  function automatic logic [4:0] modelOutputs();
    if (!rst_n) return 5'b00111;
    if (mem_branch_taken && mMode != M_HALT) return 5'b11111;
    if (mMode == M_RUN) return modelLoadUse() ? 5'b00010 : 5'b11000;
    if (mMode == M_DRAIN) return 5'b01100;
    return 5'b00110;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mMode <= M_RUN; mDrainLeft <= 0; mAck <= 0; mStall <= 0; mFlush <= 0;
    end else begin
      if (cnt_clr) begin
        mStall <= 0;
        mFlush <= 0;
      end else if (mem_branch_taken && mMode != M_HALT) begin
        mFlush <= (mFlush >= CNT_MAX) ? CNT_MAX : mFlush + 1;
      end else if (mMode == M_RUN && modelLoadUse()) begin
        mStall <= (mStall >= CNT_MAX) ? CNT_MAX : mStall + 1;
      end
      if (mMode == M_RUN && halt_req) begin
        mMode <= M_DRAIN;
        mDrainLeft <= DRAIN_N;
      end else if (mMode == M_DRAIN) begin
        mDrainLeft <= mDrainLeft - 1;
        if (mDrainLeft == 1) begin
          mMode <= M_HALT;
          mAck  <= 1;
        end
      end else if (mMode == M_HALT && !halt_req) begin
        mMode <= M_RUN;
        mAck  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checkOn) begin
      logic [4:0] e;
      e = modelOutputs();
      checkOutput("pc_en",       pc_en,       e[4]);
      checkOutput("ifid_en",     ifid_en,     e[3]);
      checkOutput("ifid_flush",  ifid_flush,  e[2]);
      checkOutput("idex_flush",  idex_flush,  e[1]);
      checkOutput("exmem_flush", exmem_flush, e[0]);
      checkOutput("halt_ack",    halt_ack,    mAck);
      checkOutput("stall_cnt",   stall_cnt,   mStall);
      checkOutput("flush_cnt",   flush_cnt,   mFlush);
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1, 1, 5, 5, 5, 1, 1, 1, 0);
    checkOn = 1'b1;
    nextCycle();
    nextCycle();
    checkOutput("rst pc_en", pc_en, 0);
    checkOutput("rst ifid_en", ifid_en, 0);
    checkOutput("rst flushes", {ifid_flush, idex_flush, exmem_flush}, 7);
    checkOutput("rst halt_ack", halt_ack, 0);
    checkOutput("rst counters", {stall_cnt, flush_cnt}, 0);

    idle();
    rst_n = 1'b1;
    #1;
    checkOutput("run pc_en", pc_en, 1);
    checkOutput("run flushes", {ifid_flush, idex_flush, exmem_flush}, 0);

    nextCycle();
    applyStimulus(1, 1, 5, 5, 0, 0, 0, 0, 0);
    #1;
    checkOutput("lu pc_en", pc_en, 0);
    checkOutput("lu ifid_en", ifid_en, 0);
    checkOutput("lu flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b010);
    nextCycle();
    idle();
    #1;
    checkOutput("lu stall_cnt", stall_cnt, 1);

    nextCycle();
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("x0 pc_en", pc_en, 1);
    nextCycle();
    applyStimulus(1, 1, 5, 3, 5, 0, 0, 0, 0);
    #1;
    checkOutput("rs2 unused pc_en", pc_en, 1);
    nextCycle();
    applyStimulus(1, 1, 5, 3, 5, 1, 0, 0, 0);
    #1;
    checkOutput("rs2 used pc_en", pc_en, 0);

    nextCycle();
    applyStimulus(1, 1, 5, 5, 0, 0, 1, 0, 0);
    #1;
    checkOutput("br+lu pc_en", pc_en, 1);
    checkOutput("br+lu flushes", {ifid_flush, idex_flush, exmem_flush}, 7);
    nextCycle();
    idle();
    #1;
    checkOutput("br+lu flush_cnt", flush_cnt, 1);
    checkOutput("br+lu stall_cnt", stall_cnt, 2);

    // Full halt handshake
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    checkOutput("halt req cycle pc_en", pc_en, 1);
    for (int i = 0; i < DRAIN_N; i++) begin
      nextCycle();
      checkOutput("drain pc_en", pc_en, 0);
      checkOutput("drain ifid_flush", ifid_flush, 1);
      checkOutput("drain halt_ack", halt_ack, 0);
    end
    nextCycle();
    checkOutput("halted ack", halt_ack, 1);
    checkOutput("halted pc_en", pc_en, 0);
    halt_req = 1'b0;
    nextCycle();
    checkOutput("resume ack", halt_ack, 0);
    checkOutput("resume pc_en", pc_en, 1);

    // One-cycle halt pulse with a branch in the second drain cycle
    halt_req = 1'b1;
    nextCycle();
    halt_req = 1'b0;
    #1;
    checkOutput("pulse drain1 pc_en", pc_en, 0);
    nextCycle();
    mem_branch_taken = 1'b1;
    #1;
    checkOutput("drain br pc_en", pc_en, 1);
    checkOutput("drain br flushes", {ifid_flush, idex_flush, exmem_flush}, 7);
    nextCycle();
    mem_branch_taken = 1'b0;
    #1;
    checkOutput("drain3 pc_en", pc_en, 0);
    checkOutput("drain br flush_cnt", flush_cnt, 2);
    nextCycle();
    checkOutput("drain4 ack", halt_ack, 0);
    nextCycle();
    checkOutput("pulse ack high", halt_ack, 1);
    nextCycle();
    checkOutput("pulse ack low", halt_ack, 0);
    checkOutput("pulse pc_en", pc_en, 1);

    // Saturation and clear
    applyStimulus(1, 1, 5, 5, 0, 0, 0, 0, 0);
    repeat (20) nextCycle();
    checkOutput("sat stall_cnt", stall_cnt, CNT_MAX);
    cnt_clr = 1'b1;
    nextCycle();
    idle();
    #1;
    checkOutput("clr stall_cnt", stall_cnt, 0);
    checkOutput("clr flush_cnt", flush_cnt, 0);

    // Asynchronous reset in DRAIN and in HALTED
    halt_req = 1'b1;
    nextCycle();
    nextCycle();
    checkOutput("pre-rst drain ifid_en", ifid_en, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst drain ifid_en", ifid_en, 0);
    checkOutput("rst drain ack", halt_ack, 0);
    halt_req = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    halt_req = 1'b1;
    repeat (DRAIN_N + 1) nextCycle();
    checkOutput("pre-rst halted ack", halt_ack, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst halted ack", halt_ack, 0);
    halt_req = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("post-rst pc_en", pc_en, 1);
    repeat (2) nextCycle();
    checkOn = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage riscv core (IF, ID, EX, MEM, WB).
- Detects load-use hazards and stalls PC and IF/ID while injecting an ID/EX bubble.
- Flushes the three younger stages when a branch resolves taken in MEM.
- Runs a halt/drain handshake so an external agent can quiesce the core.
- Keeps saturating stall and flush performance counters.

Parameters:
DRAIN_CYCLES, 4, cycles of bubble injection before halt_ack; legal range 1..15
CNT_W, 32, width of performance counters

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
id_valid  input  1  IF/ID holds a real instruction
id_rs1  input  5  rs1 field of the instruction in IF/ID
id_rs2  input  5  rs2 field of the instruction in IF/ID
id_uses_rs2  input  1  IF/ID instruction reads rs2 (R-type, S-type, B-type)
ex_memread  input  1  ID/EX instruction is a load
ex_rd  input  5  destination register of ID/EX instruction
mem_branch_taken  input  1  branch in EX/MEM resolved taken (branch & zero)
halt_req  input  1  external halt request, level
cnt_clr  input  1  synchronous clear of both counters
pc_en  output  1  PC register load enable
ifid_en  output  1  IF/ID register load enable
ifid_flush  output  1  load bubble (zero) into IF/ID
idex_flush  output  1  zero control bits entering ID/EX
exmem_flush  output  1  zero control bits entering EX/MEM
halt_ack  output  1  pipeline drained and halted, registered
stall_cnt  output  CNT_W  load-use stall cycles, saturating
flush_cnt  output  CNT_W  taken-branch flush events, saturating

Behaviour:
- While rst_n is low:
  - state=RUN, drain_ctr=0, halt_ack=0, stall_cnt=0, flush_cnt=0.
  - Outputs forced: pc_en=0, ifid_en=0, all three flush outputs=1.
- States: RUN, DRAIN, HALTED.
- Hazard and flush outputs are combinational from inputs and state, with zero-cycle latency. The state, counters and halt_ack are registered.
- load_use = id_valid & ex_memread & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- Priority 1, mem_branch_taken (any state except HALTED):
  - pc_en=1, ifid_en=1.
  - ifid_flush=idex_flush=exmem_flush=1.
  - load_use is ignored that cycle.
  - flush_cnt+1.
- Priority 2, RUN & load_use:
  - pc_en=0, ifid_en=0, idex_flush=1, other flushes 0.
  - stall_cnt+1.
  - Consecutive load_use cycles each count.
- RUN, otherwise: pc_en=1, ifid_en=1, all flushes 0.
- RUN & halt_req (sampled at the clock edge): next state DRAIN, drain_ctr<=DRAIN_CYCLES-1.
  - Same-cycle outputs still follow the RUN rules above.
- DRAIN, no branch:
  - pc_en=0, ifid_en=1, ifid_flush=1, other flushes 0.
  - load_use is not evaluated.
  - drain_ctr decrements each cycle; at drain_ctr==0 the next state is HALTED and halt_ack<=1.
- DRAIN with branch taken: apply the priority 1 outputs. drain_ctr keeps counting and is not restarted, because the fetched target is flushed.
- Dropping halt_req during DRAIN does not abort the drain. HALTED is still entered, then exits on the next cycle, giving a one-cycle halt_ack pulse.
- HALTED:
  - pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, exmem_flush=0.
  - mem_branch_taken is ignored, since no branch can be in flight.
  - halt_req low: next state RUN and halt_ack<=0, so halt_ack deasserts on the same edge.
- Counters:
  - Both saturate at 2^CNT_W-1.
  - cnt_clr has priority over increment; the cleared value is 0 on the next cycle.
- A reset assertion mid-DRAIN or mid-HALTED returns immediately and asynchronously to the reset values.

Decomposition:
- hazard_pkg holds:
  - typedef enum logic [1:0] {RUN, DRAIN, HALTED} hz_state_t
  - localparam REG_ZERO = 5'd0
- One sub-module, sat_counter (parameter W; ports clk, rst_n, clr, inc, count), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset check: rst_n=0 with arbitrary inputs -> pc_en=0, ifid_en=0, all flushes=1, halt_ack=0, counters 0.
- Release reset with idle inputs -> pc_en=1, ifid_en=1, all flushes 0 in the first cycle.
- Load-use stall: ex_memread=1, ex_rd=5, id_rs1=5, id_valid=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1, stall_cnt=1.
- Load to x0 suppresses the stall: ex_rd=0, id_rs1=0 -> no stall.
- rs2 case: id_rs2=5, id_uses_rs2=0 -> no stall; id_uses_rs2=1 -> stall.
- Simultaneous events: load_use and mem_branch_taken in the same cycle -> pc_en=1, all three flushes=1, flush_cnt=1, stall_cnt unchanged.
- Halt handshake (DRAIN_CYCLES=4): halt_req rises at edge N.
  - Expected: DRAIN during cycles N+1..N+4 with pc_en=0, ifid_flush=1.
  - halt_ack=1 from edge N+4.
  - Drop halt_req -> halt_ack=0 and pc_en=1 one cycle later.
- Drain abort and branch inside DRAIN:
  - halt_req pulsed for 1 cycle -> drain completes, halt_ack high exactly 1 cycle, then RUN.
  - Branch taken in the 2nd DRAIN cycle -> all flushes=1, pc_en=1, halt_ack still at N+4.
- Counter saturation and clear with CNT_W=4:
  - 20 stall cycles -> stall_cnt=15.
  - cnt_clr concurrent with load_use -> stall_cnt=0 next cycle.
  - rst_n low mid-DRAIN -> state RUN and halt_ack=0 immediately.
